// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI write initiator that
// drives the spi_peripheral register block.
package spi_pkg;

  localparam logic [3:0] ADDR_EN_OUT_7_0  = 4'd0;
  localparam logic [3:0] ADDR_EN_OUT_15_8 = 4'd1;
  localparam logic [3:0] ADDR_EN_PWM_7_0  = 4'd2;
  localparam logic [3:0] ADDR_EN_PWM_15_8 = 4'd3;
  localparam logic [3:0] ADDR_PWM_DUTY    = 4'd4;
  localparam logic [3:0] ADDR_MAX         = ADDR_PWM_DUTY;

  localparam logic [7:0] WRITE_CMD = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: tick pulses on every CLK_DIV-th enabled cycle and the
// count restarts from zero whenever enable drops.
module spi_tick_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: one request becomes a command frame then a data
// frame; done rises exactly 2*(17*CLK_DIV+NCS_GAP) cycles after the accept edge.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int NCS_GAP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);

  localparam int GW = $clog2(NCS_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(NCS_GAP - 1);

  spi_state_t    state, state_nxt;
  logic          byte_sel, byte_sel_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [GW-1:0] gap_cnt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          err_q, err_nxt;
  logic          sclk_q, sclk_nxt;
  logic          ncs_q, ncs_nxt;
  logic          copi_q, copi_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          tick_en, tick, gap_done;

  assign tick_en  = (state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO);
  assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt    = state;
    byte_sel_nxt = byte_sel;
    bit_cnt_nxt  = bit_cnt;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    shreg_nxt    = shreg;
    data_nxt     = data_q;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_addr > ADDR_MAX) begin
            err_nxt = 1'b1;
          end else begin
            data_nxt     = req_data;
            shreg_nxt    = WRITE_CMD | {4'b0000, req_addr};
            busy_nxt     = 1'b1;
            byte_sel_nxt = 1'b0;
            bit_cnt_nxt  = 3'd7;
            state_nxt    = SETUP;
          end
        end
      end
      SETUP: begin
        if (tick) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        // The falling edge is where the next bit is presented.
        if (tick) begin
          shreg_nxt = {shreg[6:0], 1'b0};
          state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          if (bit_cnt == 3'd0) begin
            state_nxt = GAP;
          end else begin
            bit_cnt_nxt = bit_cnt - 3'd1;
            state_nxt   = SHIFT_HI;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          if (!byte_sel) begin
            byte_sel_nxt = 1'b1;
            bit_cnt_nxt  = 3'd7;
            shreg_nxt    = data_q;
            state_nxt    = SETUP;
          end else begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Pins are registered from the next state so they line up with it.
    ncs_nxt  = !(state_nxt inside {SETUP, SHIFT_HI, SHIFT_LO});
    sclk_nxt = (state_nxt == SHIFT_HI);
    copi_nxt = ncs_nxt ? 1'b0 : shreg_nxt[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_sel <= 1'b0;
      bit_cnt  <= 3'd7;
      gap_cnt  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sclk_q   <= 1'b0;
      ncs_q    <= 1'b1;
      copi_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_sel <= byte_sel_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= (state == GAP && !gap_done) ? gap_cnt + GW'(1) : '0;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      sclk_q   <= sclk_nxt;
      ncs_q    <= ncs_nxt;
      copi_q   <= copi_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg  <= shreg_nxt;
    data_q <= data_nxt;
  end

  assign req_ready = !busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign SCLK      = sclk_q;
  assign nCS       = ncs_q;
  assign COPI      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV 8 and 4), a pin-level
// timing monitor and a behavioural model of the spi_peripheral registers.
module tb_spi_controller;

  localparam int LAT0 = 2 * (17 * 8 + 16);
  localparam int LAT1 = 2 * (17 * 4 + 4);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic       busy [2];
  logic       done [2];
  logic       err  [2];
  logic       sclk [2];
  logic       ncs  [2];
  logic       copi [2];

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(8), .NCS_GAP(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .SCLK(sclk[0]), .nCS(ncs[0]), .COPI(copi[0])
  );

  spi_controller #(.CLK_DIV(4), .NCS_GAP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .SCLK(sclk[1]), .nCS(ncs[1]), .COPI(copi[1])
  );

  function automatic int cdv(input int g);
    return (g == 0) ? 8 : 4;
  endfunction

  function automatic int gpv(input int g);
    return (g == 0) ? 16 : 4;
  endfunction

  // Monitor state, written only by the monitor process.
  int         fcnt [2];
  int         viol [2];
  logic [7:0] flog [2][64];
  logic [7:0] pregs [2][5];
  int         run [2], edges [2], last_rise [2], last_chg [2], tcnt;
  logic       pn [2], ps [2], pc [2], started [2], pph [2];
  logic [3:0] paddr [2];
  logic [7:0] shb [2];

  always @(negedge clk) begin
    logic n, s, c;
    tcnt++;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        pn[g] = 1'b1; ps[g] = 1'b0; pc[g] = 1'b0; run[g] = 0; edges[g] = 0;
        started[g] = 1'b0; pph[g] = 1'b0; paddr[g] = 4'd0; shb[g] = 8'd0;
        last_rise[g] = -1000; last_chg[g] = -1000;
        for (int r = 0; r < 5; r++) pregs[g][r] = 8'd0;
      end else begin
        n = ncs[g]; s = sclk[g]; c = copi[g];
        if (c != pc[g]) begin
          if (tcnt - last_rise[g] < cdv(g)) viol[g]++;
          last_chg[g] = tcnt;
        end
        if (s && !ps[g]) begin
          if (n) viol[g]++;
          if (tcnt - last_chg[g] < cdv(g)) viol[g]++;
          last_rise[g] = tcnt;
          edges[g]++;
          shb[g] = {shb[g][6:0], c};
        end
        if ({n, s} != {pn[g], ps[g]}) begin
          if (!pn[g] && run[g] != cdv(g)) viol[g]++;
          if (pn[g] && !n && started[g] && run[g] < gpv(g)) viol[g]++;
          run[g] = 1;
        end else begin
          run[g]++;
        end
        if (!n && pn[g]) edges[g] = 0;
        if (n && !pn[g]) begin
          started[g] = 1'b1;
          if (edges[g] == 8) begin
            flog[g][fcnt[g] % 64] = shb[g];
            fcnt[g]++;
            if (!pph[g]) begin
              if (shb[g][7]) begin paddr[g] = shb[g][3:0]; pph[g] = 1'b1; end
            end else begin
              if (paddr[g] <= 4'd4) pregs[g][paddr[g]] = shb[g];
              pph[g] = 1'b0;
            end
          end else begin
            viol[g]++;
          end
          edges[g] = 0;
        end
        pn[g] = n; ps[g] = s; pc[g] = c;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_regs [2][5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input int g, input string name);
    int m = 0;
    for (int r = 0; r < 5; r++) if (pregs[g][r] !== exp_regs[g][r]) m++;
    check(name, m, 0);
  endtask

  // One request; samples from the accept edge (k=0) through k=limit.
  task automatic send(input int g, input logic [3:0] a, input logic [7:0] d, input int limit,
                      output int lat, output int nd, output int ne, output int elat,
                      output int nrl, output int nlo, output logic b0);
    @(posedge clk); #1;
    req_valid[g] = 1'b1; req_addr[g] = a; req_data[g] = d;
    @(posedge clk); #1;
    req_valid[g] = 1'b0; req_addr[g] = ~a; req_data[g] = ~d;
    lat = -1; elat = -1; nd = 0; ne = 0; nrl = 0; nlo = 0; b0 = busy[g];
    for (int k = 0; k <= limit; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done[g]) begin nd++; if (lat < 0) lat = k; end
      if (err[g]) begin ne++; if (elat < 0) elat = k; end
      if (!req_ready[g]) nrl++;
      if (!ncs[g]) nlo++;
      if (done[g] && err[g]) ne += 100;
    end
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         ill;
    logic [7:0] cmd;
  } vec_t;

  vec_t vt [6];

  initial begin
    int lat, nd, ne, elat, nrl, nlo, f0, v0, nr;
    logic b0, lastsc;

    vt[0] = '{4'd0,  8'hA5, 1'b0, 8'h80};
    vt[1] = '{4'd4,  8'h80, 1'b0, 8'h84};
    vt[2] = '{4'd7,  8'h12, 1'b1, 8'h00};
    vt[3] = '{4'd2,  8'hFF, 1'b0, 8'h82};
    vt[4] = '{4'd15, 8'h3C, 1'b1, 8'h00};
    vt[5] = '{4'd5,  8'h00, 1'b1, 8'h00};

    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_addr[g] = 4'd0; req_data[g] = 8'd0;
      for (int r = 0; r < 5; r++) exp_regs[g][r] = 8'd0;
    end

    #2 rst_n = 1'b0;
    #1;
    check("reset_ncs", ncs[0], 1);
    check("reset_sclk", sclk[0], 0);
    check("reset_copi", copi[0], 0);
    check("reset_busy", busy[0], 0);
    check("reset_done", done[0], 0);
    check("reset_err", err[0], 0);
    check("reset_ready", req_ready[0], 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      f0 = fcnt[0]; v0 = viol[0];
      send(0, vt[i].addr, vt[i].data, vt[i].ill ? 40 : LAT0 + 4, lat, nd, ne, elat, nrl, nlo, b0);
      if (vt[i].ill) begin
        check("ill_err_count", ne, 1);
        check("ill_err_cycle", elat, 0);
        check("ill_no_done", nd, 0);
        check("ill_ncs_high", nlo, 0);
        check("ill_ready_high", nrl, 0);
        check("ill_no_frames", fcnt[0] - f0, 0);
      end else begin
        exp_regs[0][vt[i].addr] = vt[i].data;
        check("wr_busy", b0, 1);
        check("wr_latency", lat, LAT0);
        check("wr_done_count", nd, 1);
        check("wr_no_err", ne, 0);
        check("wr_frame_count", fcnt[0] - f0, 2);
        check("wr_cmd_byte", flog[0][f0 % 64], vt[i].cmd);
        check("wr_data_byte", flog[0][(f0 + 1) % 64], vt[i].data);
        check_regs(0, "wr_regs");
      end
      check("timing_cd8", viol[0] - v0, 0);
    end

    // Back-to-back with req_valid held high throughout.
    f0 = fcnt[0]; v0 = viol[0];
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 4'd1; req_data[0] = 8'h3C;
    @(posedge clk); #1;
    check("b2b_first_accept", busy[0], 1);
    lat = -1; nrl = 0;
    for (int k = 0; k < LAT0 + 20 && lat < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done[0]) lat = k;
      else if (req_ready[0]) nrl++;
    end
    check("b2b_first_latency", lat, LAT0);
    check("b2b_ready_low_while_busy", nrl, 0);
    check("b2b_ready_in_done_cycle", req_ready[0], 1);
    req_addr[0] = 4'd3; req_data[0] = 8'hF0;
    @(posedge clk); #1;
    check("b2b_second_accept", busy[0], 1);
    req_valid[0] = 1'b0;
    lat = -1;
    for (int k = 0; k < LAT0 + 20 && lat < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done[0]) lat = k;
    end
    check("b2b_second_latency", lat, LAT0);
    check("b2b_frame_count", fcnt[0] - f0, 4);
    check("b2b_byte0", flog[0][f0 % 64], 8'h81);
    check("b2b_byte1", flog[0][(f0 + 1) % 64], 8'h3C);
    check("b2b_byte2", flog[0][(f0 + 2) % 64], 8'h83);
    check("b2b_byte3", flog[0][(f0 + 3) % 64], 8'hF0);
    exp_regs[0][1] = 8'h3C; exp_regs[0][3] = 8'hF0;
    check_regs(0, "b2b_regs");
    check("b2b_timing", viol[0] - v0, 0);

    // Fast instance at the minimum divider and gap.
    f0 = fcnt[1]; v0 = viol[1];
    send(1, 4'd3, 8'h5A, LAT1 + 4, lat, nd, ne, elat, nrl, nlo, b0);
    check("cd4_latency", lat, LAT1);
    check("cd4_done_count", nd, 1);
    check("cd4_frame_count", fcnt[1] - f0, 2);
    check("cd4_cmd_byte", flog[1][f0 % 64], 8'h83);
    check("cd4_data_byte", flog[1][(f0 + 1) % 64], 8'h5A);
    exp_regs[1][3] = 8'h5A;
    check_regs(1, "cd4_regs");
    check("timing_cd4", viol[1] - v0, 0);

    // Asynchronous reset partway through the command frame.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 4'd0; req_data[0] = 8'h11;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    nr = 0; lastsc = sclk[0];
    for (int k = 0; k < 300 && nr < 3; k++) begin
      @(posedge clk); #1;
      if (sclk[0] && !lastsc) nr++;
      lastsc = sclk[0];
    end
    check("rst_third_edge", nr, 3);
    f0 = fcnt[0];
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ncs", ncs[0], 1);
    check("midrst_sclk", sclk[0], 0);
    check("midrst_copi", copi[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", req_ready[0], 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < 5; r++) exp_regs[g][r] = 8'd0;
    check("midrst_no_commit", fcnt[0] - f0, 0);
    v0 = viol[0];
    send(0, 4'd2, 8'h55, LAT0 + 4, lat, nd, ne, elat, nrl, nlo, b0);
    check("post_rst_latency", lat, LAT0);
    check("post_rst_cmd", flog[0][f0 % 64], 8'h82);
    check("post_rst_data", flog[0][(f0 + 1) % 64], 8'h55);
    exp_regs[0][2] = 8'h55;
    check_regs(0, "post_rst_regs");
    check("post_rst_timing", viol[0] - v0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
